// File: rtl/vs_hex_word_assembler.sv
// Assembles decoded hex digits from the UART receive stream into a binary word ended by CR or LF.
// One-cycle registered latency; errors and completed words are reported as single-cycle pulses.
module vs_hex_word_assembler #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  input  logic [3:0]            HEX,
  input  logic                  HEX_FLG,
  output logic [4*DIGITS-1:0]   WORD,
  output logic                  WORD_VALID,
  output logic                  ERR,
  output logic [1:0]            ERR_CODE,
  output logic [CNT_W-1:0]      DIGIT_CNT,
  output logic                  BUSY
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic           is_term;
  logic           is_abort;
  logic           cnt_full;

  assign is_term  = (RX_DATA == 8'h0D) || (RX_DATA == 8'h0A);
  assign is_abort = (RX_DATA == 8'h1B);
  assign cnt_full = (DIGIT_CNT == CNT_W'(DIGITS));

  // Class priority is TERM, then ABORT, then DIGIT, then OTHER.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      acc        <= '0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= 2'b00;
      DIGIT_CNT  <= '0;
      BUSY       <= 1'b0;
    end else begin
      WORD_VALID <= 1'b0;
      ERR        <= 1'b0;
      if (RX_VALID) begin
        case (state)
          IDLE: begin
            if (is_term || is_abort) begin
              state <= IDLE;
            end else if (HEX_FLG) begin
              acc       <= W'(HEX);
              DIGIT_CNT <= CNT_W'(1);
              state     <= COLLECT;
              BUSY      <= 1'b1;
            end else begin
              ERR      <= 1'b1;
              ERR_CODE <= 2'b01;
              state    <= DISCARD;
              BUSY     <= 1'b1;
            end
          end
          COLLECT: begin
            if (is_term) begin
              WORD       <= acc;
              WORD_VALID <= 1'b1;
              acc        <= '0;
              DIGIT_CNT  <= '0;
              state      <= IDLE;
              BUSY       <= 1'b0;
            end else if (is_abort) begin
              acc       <= '0;
              DIGIT_CNT <= '0;
              state     <= IDLE;
              BUSY      <= 1'b0;
            end else if (HEX_FLG && !cnt_full) begin
              acc       <= (acc << 4) | W'(HEX);
              DIGIT_CNT <= DIGIT_CNT + CNT_W'(1);
            end else begin
              ERR       <= 1'b1;
              ERR_CODE  <= HEX_FLG ? 2'b10 : 2'b01;
              acc       <= '0;
              DIGIT_CNT <= '0;
              state     <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term || is_abort) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vs_hex_word_assembler.sv
// Bench for vs_hex_word_assembler: directed scenarios then random byte streams against a queue-based model.
module tb_vs_hex_word_assembler;

  localparam int DIGITS = 4;
  localparam int CNT_W  = 3;
  localparam int W      = 4 * DIGITS;

  logic             CLK;
  logic             RST;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic [3:0]       HEX;
  logic             HEX_FLG;
  logic [W-1:0]     WORD;
  logic             WORD_VALID;
  logic             ERR;
  logic [1:0]       ERR_CODE;
  logic [CNT_W-1:0] DIGIT_CNT;
  logic             BUSY;

  vs_hex_word_assembler #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .HEX(HEX), .HEX_FLG(HEX_FLG), .WORD(WORD), .WORD_VALID(WORD_VALID),
    .ERR(ERR), .ERR_CODE(ERR_CODE), .DIGIT_CNT(DIGIT_CNT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the pending digits as a list, plus a "skipping to terminator" flag.
  int          digits_q[$];
  bit          discarding;
  logic [W-1:0] m_word;
  logic [1:0]  m_code;
  bit          m_wv;
  bit          m_err;

  function automatic void decode(input logic [7:0] b, output logic flg, output logic [3:0] nib);
    flg = 1'b1;
    nib = 4'h0;
    if (b >= "0" && b <= "9")      nib = 4'(b - "0");
    else if (b >= "a" && b <= "f") nib = 4'(b - "a" + 10);
    else if (b >= "A" && b <= "F") nib = 4'(b - "A" + 10);
    else                           flg = 1'b0;
  endfunction

  function automatic void model_reset();
    digits_q.delete();
    discarding = 0;
    m_word = '0;
    m_code = 2'b00;
    m_wv = 0;
    m_err = 0;
  endfunction

  function automatic void model_byte(input bit v, input logic [7:0] b);
    logic flg;
    logic [3:0] nib;
    bit term, abort;
    longint acc;
    m_wv = 0;
    m_err = 0;
    if (!v) return;
    decode(b, flg, nib);
    term  = (b == 8'h0D) || (b == 8'h0A);
    abort = (b == 8'h1B);
    if (discarding) begin
      if (term || abort) discarding = 0;
    end else if (term) begin
      if (digits_q.size() > 0) begin
        acc = 0;
        foreach (digits_q[i]) acc = acc * 16 + digits_q[i];
        m_word = W'(acc);
        m_wv = 1;
        digits_q.delete();
      end
    end else if (abort) begin
      digits_q.delete();
    end else if (flg) begin
      if (digits_q.size() == DIGITS) begin
        m_err = 1; m_code = 2'b10; discarding = 1;
        digits_q.delete();
      end else begin
        digits_q.push_back(int'(nib));
      end
    end else begin
      m_err = 1; m_code = 2'b01; discarding = 1;
      digits_q.delete();
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".word"},       32'(WORD),       32'(m_word));
    chk({ctx, ".word_valid"}, 32'(WORD_VALID), 32'(m_wv));
    chk({ctx, ".err"},        32'(ERR),        32'(m_err));
    chk({ctx, ".err_code"},   32'(ERR_CODE),   32'(m_code));
    chk({ctx, ".digit_cnt"},  32'(DIGIT_CNT),  32'(digits_q.size()));
    chk({ctx, ".busy"},       32'(BUSY),       32'(discarding || digits_q.size() > 0));
    vectors++;
  endtask

  task automatic step(input bit v, input logic [7:0] b, input string ctx);
    logic flg;
    logic [3:0] nib;
    decode(b, flg, nib);
    @(negedge CLK);
    RX_VALID = v;
    RX_DATA  = b;
    HEX      = nib;
    HEX_FLG  = flg;
    @(posedge CLK);
    #1;
    model_byte(v, b);
    check_all(ctx);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input string ctx);
    step(1'b1, b, ctx);
    for (int g = 0; g < gap; g++) step(1'b0, 8'h00, {ctx, ".gap"});
  endtask

  logic [7:0] hexchars [22];
  logic [7:0] others [4];

  initial begin
    logic [7:0] b;
    int r;
    hexchars = '{"0","1","2","3","4","5","6","7","8","9","a","b","c","d","e","f",
                 "A","B","C","D","E","F"};
    others = '{"G", "z", " ", ":"};
    RST = 1'b1;
    RX_VALID = 1'b0;
    RX_DATA = 8'h00;
    HEX = 4'h0;
    HEX_FLG = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;
    step(1'b0, 8'h00, "post_reset");

    // Paced word "12aF"
    send("1", 3, "p1_1");
    send("2", 3, "p1_2");
    send("a", 3, "p1_a");
    send("F", 3, "p1_F");
    step(1'b1, 8'h0D, "p1_cr");
    chk("p1_word_value", 32'(WORD), 32'h12AF);
    chk("p1_wv_pulse", 32'(WORD_VALID), 32'd1);
    step(1'b0, 8'h00, "p1_after");

    // CR LF back-to-back gives a single word
    send("7", 0, "p2_7");
    send(8'h0D, 0, "p2_cr");
    chk("p2_word_value", 32'(WORD), 32'h0007);
    send(8'h0A, 2, "p2_lf");

    // Digit overflow
    send("1", 0, "p3_1");
    send("2", 0, "p3_2");
    send("3", 0, "p3_3");
    send("4", 0, "p3_4");
    send("5", 0, "p3_5");
    chk("p3_err_code", 32'(ERR_CODE), 32'h2);
    send(8'h0D, 1, "p3_cr");
    chk("p3_word_held", 32'(WORD), 32'h0007);

    // Illegal character then recovery
    send("3", 0, "p4_3");
    send("G", 0, "p4_G");
    chk("p4_err_code", 32'(ERR_CODE), 32'h1);
    send("4", 0, "p4_4");
    send(8'h0A, 0, "p4_lf");
    send("9", 0, "p4_9");
    send(8'h0D, 1, "p4_cr");
    chk("p4_word_value", 32'(WORD), 32'h0009);

    // ESC abandons a partial word
    send("5", 0, "p5_5");
    send("6", 0, "p5_6");
    send(8'h1B, 0, "p5_esc");
    send("8", 0, "p5_8");
    send(8'h0D, 1, "p5_cr");
    chk("p5_word_value", 32'(WORD), 32'h0008);

    // Asynchronous reset mid-word, away from any clock edge
    send("1", 0, "p6_1");
    send("2", 0, "p6_2");
    chk("p6_cnt_before", 32'(DIGIT_CNT), 32'd2);
    @(negedge CLK);
    RX_VALID = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("p6_async_rst");
    @(posedge CLK);
    #1;
    check_all("p6_rst_held");
    @(negedge CLK);
    RST = 1'b0;
    send("B", 0, "p6_B");
    send(8'h0D, 1, "p6_cr");
    chk("p6_word_value", 32'(WORD), 32'h000B);

    // Random streams biased towards digits so words and overflows both occur
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 19);
      if (r < 11)       b = hexchars[$urandom_range(0, 21)];
      else if (r == 11) b = 8'h0D;
      else if (r == 12) b = 8'h0A;
      else if (r == 13) b = 8'h1B;
      else if (r == 14) b = others[$urandom_range(0, 3)];
      else if (r == 15) b = 8'($urandom_range(0, 255));
      else if (r == 16) b = 8'h0D;
      else              b = 8'h00;
      step(r < 17, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
